// File: rtl/kiscv_alu.sv
// RV32I ALU and branch comparator; optional output register via `ALU_OUTREG_EN.
// Latency: 0 cycles (combinational) by default, 1 cycle with `ALU_OUTREG_EN.
// Backpressure: none; a new result is produced every cycle.
module kiscv_alu (
  input  logic        clk,
  input  logic        rts,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] alu_out,
  output logic        cmp_flag
);

  logic               alt;
  logic [2:0]         funct3;
  logic [4:0]         shamt;
  logic               lt_s;
  logic               lt_u;
  logic               eq;
  logic signed [31:0] sra_res;
  logic [31:0]        res_nxt;
  logic               flag_nxt;

  assign alt     = alu_op[3];
  assign funct3  = alu_op[2:0];
  assign shamt   = b[4:0];
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;
  assign eq      = (a == b);
  assign sra_res = $signed(a) >>> shamt;

  always_comb begin
    res_nxt = 32'h0;
    case (funct3)
      3'b000:  res_nxt = alt ? (a - b) : (a + b);
      3'b001:  res_nxt = a << shamt;
      3'b010:  res_nxt = {31'b0, lt_s};
      3'b011:  res_nxt = {31'b0, lt_u};
      3'b100:  res_nxt = a ^ b;
      3'b101:  res_nxt = alt ? sra_res : (a >> shamt);
      3'b110:  res_nxt = a | b;
      3'b111:  res_nxt = a & b;
      default: res_nxt = 32'h0;
    endcase
  end

  // bit 3 carries a branch-immediate bit for branches, so only funct3 selects the condition
  always_comb begin
    flag_nxt = 1'b0;
    case (funct3)
      3'b000:  flag_nxt = eq;
      3'b001:  flag_nxt = ~eq;
      3'b100:  flag_nxt = lt_s;
      3'b101:  flag_nxt = ~lt_s;
      3'b110:  flag_nxt = lt_u;
      3'b111:  flag_nxt = ~lt_u;
      default: flag_nxt = 1'b0;
    endcase
  end

`ifdef ALU_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rts) begin
      alu_out  <= 32'h0;
      cmp_flag <= 1'b0;
    end else begin
      alu_out  <= res_nxt;
      cmp_flag <= flag_nxt;
    end
  end
`else
  // clk/rts stay on the port list for drop-in compatibility with the registered build
  logic unused_clk_rts;
  assign unused_clk_rts = ^{clk, rts};

  assign alu_out  = res_nxt;
  assign cmp_flag = flag_nxt;
`endif

endmodule

// File: tb/tb_kiscv_alu.sv
// Directed bench for kiscv_alu; covers both the combinational and the `ALU_OUTREG_EN build.
module tb_kiscv_alu;

  logic        clk;
  logic        rts;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic        cmp_flag;

  int n_vec  = 0;
  int n_miss = 0;

  kiscv_alu dut (
    .clk      (clk),
    .rts      (rts),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .alu_out  (alu_out),
    .cmp_flag (cmp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    alu_op = op;
    a      = av;
    b      = bv;
`ifdef ALU_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (alu_out === exp) else begin
      n_miss++;
      $error("FAIL %s: alu_out=%h expected=%h", tag, alu_out, exp);
    end
  endtask

  task automatic chk_flag(input string tag, input logic exp);
    n_vec++;
    assert (cmp_flag === exp) else begin
      n_miss++;
      $error("FAIL %s: cmp_flag=%b expected=%b", tag, cmp_flag, exp);
    end
  endtask

  initial begin
    logic [7:0] flag_tbl;
    logic [3:0] op;

    rts    = 1'b1;
    alu_op = 4'b0000;
    a      = 32'h0;
    b      = 32'h0;

`ifdef ALU_OUTREG_EN
    // reset held for two cycles with non-zero inputs: outputs must be forced to 0
    alu_op = 4'b0000;
    a      = 32'h1234_5678;
    b      = 32'h1;
    @(posedge clk); #1;
    chk_out("rst_c1_out", 32'h0);
    chk_flag("rst_c1_flag", 1'b0);
    @(posedge clk); #1;
    chk_out("rst_c2_out", 32'h0);
    rts = 1'b0;
    alu_op = 4'b0000;
    a      = 32'd5;
    b      = 32'd7;
    #1;
    chk_out("lat_before_edge", 32'h0);
    @(posedge clk); #1;
    chk_out("lat_one_edge", 32'd12);
    rts = 1'b1;
    @(posedge clk); #1;
    chk_out("mid_rst_out", 32'h0);
    chk_flag("mid_rst_flag", 1'b0);
    rts = 1'b0;
    @(posedge clk); #1;
    chk_out("post_rst_out", 32'd12);
`else
    // combinational: reset and clock must not matter
    drive(4'b0000, 32'h0, 32'h0);
    chk_out("zero_out", 32'h0);
    chk_flag("zero_flag", 1'b1);
    drive(4'b0000, 32'd5, 32'd7);
    chk_out("comb_rts_hi", 32'd12);
    rts = 1'b0;
`endif

    drive(4'b0000, 32'h7FFF_FFFF, 32'h1);
    chk_out("add_ovf", 32'h8000_0000);
    drive(4'b1000, 32'h7FFF_FFFF, 32'h1);
    chk_out("sub", 32'h7FFF_FFFE);
    drive(4'b1000, 32'h0, 32'h1);
    chk_out("sub_wrap", 32'hFFFF_FFFF);

    drive(4'b0101, 32'h8000_0000, 32'h0000_0024);
    chk_out("srl", 32'h0800_0000);
    drive(4'b1101, 32'h8000_0000, 32'h0000_0024);
    chk_out("sra", 32'hF800_0000);
    drive(4'b0001, 32'h8000_0000, 32'h0000_0024);
    chk_out("sll", 32'h0);
    drive(4'b1001, 32'h0000_0001, 32'hFFFF_FFE4);
    chk_out("sll_alt_hi_b", 32'h0000_0010);
    drive(4'b0001, 32'h8000_0001, 32'h0);
    chk_out("sll_by0", 32'h8000_0001);
    drive(4'b0101, 32'h8000_0001, 32'h0);
    chk_out("srl_by0", 32'h8000_0001);
    drive(4'b1101, 32'h8000_0001, 32'h0);
    chk_out("sra_by0", 32'h8000_0001);
    drive(4'b1101, 32'h4000_0000, 32'h1F);
    chk_out("sra_pos", 32'h0);

    drive(4'b0010, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt", 32'h1);
    drive(4'b1010, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt_alt", 32'h1);
    drive(4'b0011, 32'hFFFF_FFFF, 32'h1);
    chk_out("sltu", 32'h0);
    drive(4'b0011, 32'h1, 32'hFFFF_FFFF);
    chk_out("sltu_t", 32'h1);
    drive(4'b0010, 32'h55, 32'h55);
    chk_out("slt_eq", 32'h0);
    drive(4'b0011, 32'h55, 32'h55);
    chk_out("sltu_eq", 32'h0);

    drive(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("xor", 32'hFF00_FF00);
    drive(4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("xor_alt", 32'hFF00_FF00);
    drive(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("or", 32'hFFF0_FFF0);
    drive(4'b1110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("or_alt", 32'hFFF0_FFF0);
    drive(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("and", 32'h00F0_00F0);
    drive(4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_out("and_alt", 32'h00F0_00F0);

    // -2 vs 3: expected flag per funct3 (bit i = funct3 i): 7:1 6:0 5:0 4:1 3:0 2:0 1:1 0:0
    flag_tbl = 8'b1001_0010;
    for (int i = 0; i < 16; i++) begin
      op = i[3:0];
      drive(op, 32'hFFFF_FFFE, 32'h3);
      chk_flag($sformatf("br_neg2_3_op%b", op), flag_tbl[op[2:0]]);
    end
    // a == b: eq, signed ge and unsigned ge true
    flag_tbl = 8'b1010_0001;
    for (int i = 0; i < 8; i++) begin
      op = i[3:0];
      drive(op, 32'h8000_0000, 32'h8000_0000);
      chk_flag($sformatf("br_eq_op%b", op), flag_tbl[op[2:0]]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
